// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and build-time sizes for the register file
// write-back path. RV32E builds shrink the architectural register count.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
`ifdef RV32E
    localparam int NREGS      = 16;
`else
    localparam int NREGS      = 32;
`endif
    localparam int TAG_DEPTH  = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/wb_tag_fifo.sv
// wb_tag_fifo: in-order FIFO of outstanding load destination tags.
// Ports: clk, reset (sync, active-high); push/push_rd enqueue a tag;
// pop dequeues head_rd; full/empty flags; q_alu/q_rs1/q_rs2 are
// query addresses with parallel match outputs m_alu/m_rs1/m_rs2
// (true when any valid entry holds that nonzero address).
module wb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_rd,
    input  logic          pop,
    output logic [AW-1:0] head_rd,
    output logic          full,
    output logic          empty,
    input  logic [AW-1:0] q_alu,
    input  logic [AW-1:0] q_rs1,
    input  logic [AW-1:0] q_rs2,
    output logic          m_alu,
    output logic          m_rs1,
    output logic          m_rs2
);

    // DEPTH is a power of two (>= 2) so pointers wrap naturally.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    tags [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;

    // Pop clears before push sets, so a push into the slot being
    // vacated on a full FIFO keeps that slot valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + 1'b1;
            end
            if (push) begin
                vld[wptr]  <= 1'b1;
                tags[wptr] <= push_rd;
                wptr       <= wptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_rd = tags[rptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    function automatic logic hit(input logic [AW-1:0] r);
        logic h;
        h = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (tags[i] == r)) begin
                h = 1'b1;
            end
        end
        return h && (r != '0);
    endfunction

    assign m_alu = hit(q_alu);
    assign m_rs1 = hit(q_rs1);
    assign m_rs2 = hit(q_rs2);

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU results and in-order load returns onto
// the single registered register-file write port, and flags busy decode
// sources. Ports: clk, reset (sync, active-high); alu_valid/rd/data with
// alu_ready; load_issue_valid/rd with load_issue_ready; load_done_valid
// /data (no back-pressure); rs1/rs2 -> busy1/busy2; registered write
// port regWrite/writeRegister/writeData; sticky proto_err.
module regfile_writeback #(
    parameter int XLEN      = regfile_pkg::XLEN,
    parameter int NREGS     = regfile_pkg::NREGS,
    parameter int TAG_DEPTH = regfile_pkg::TAG_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            load_issue_valid,
    input  logic [4:0]      load_issue_rd,
    output logic            load_issue_ready,
    input  logic            load_done_valid,
    input  logic [XLEN-1:0] load_done_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            busy1,
    output logic            busy2,
    output logic            regWrite,
    output logic [4:0]      writeRegister,
    output logic [XLEN-1:0] writeData,
    output logic            proto_err
);

    import regfile_pkg::*;

    reg_addr_t head_rd;
    logic      full;
    logic      empty;
    logic      m_alu;
    logic      m_rs1;
    logic      m_rs2;
    logic      push;
    logic      pop;
    logic      alu_acc;

    // x0 and registers beyond NREGS never get written.
    function automatic logic wr_ok(input reg_addr_t rd);
        return (rd != '0) && (32'(rd) < 32'(NREGS));
    endfunction

    assign pop              = load_done_valid && !empty;
    assign load_issue_ready = !full || load_done_valid;
    assign push             = load_issue_valid && load_issue_ready;

    // Load returns own the port; an ALU write to a register with a
    // load still outstanding would be overwritten out of order.
    assign alu_ready = !load_done_valid && !m_alu;
    assign alu_acc   = alu_valid && alu_ready;

    wb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .AW    (REG_ADDR_W)
    ) u_tags (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_rd (load_issue_rd),
        .pop     (pop),
        .head_rd (head_rd),
        .full    (full),
        .empty   (empty),
        .q_alu   (alu_rd),
        .q_rs1   (rs1),
        .q_rs2   (rs2),
        .m_alu   (m_alu),
        .m_rs1   (m_rs1),
        .m_rs2   (m_rs2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            proto_err     <= 1'b0;
        end else begin
            regWrite <= 1'b0;
            if (pop) begin
                if (wr_ok(head_rd)) begin
                    regWrite      <= 1'b1;
                    writeRegister <= head_rd;
                    writeData     <= load_done_data;
                end
            end else if (alu_acc && wr_ok(alu_rd)) begin
                regWrite      <= 1'b1;
                writeRegister <= alu_rd;
                writeData     <= alu_data;
            end
            if (load_done_valid && empty) begin
                proto_err <= 1'b1;
            end
        end
    end

    // The write-port term covers the cycle the registered write is in
    // flight and not yet readable from the register file.
    assign busy1 = (rs1 != '0) &&
                   (m_rs1 || (regWrite && (writeRegister == rs1)));
    assign busy2 = (rs2 != '0) &&
                   (m_rs2 || (regWrite && (writeRegister == rs2)));

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side controller for the core's single-write-port register file.
- Merges ALU results and in-order load completions onto one registered write port (regWrite / writeRegister / writeData).
- Tracks destination tags of outstanding loads and reports busy status for decode-stage source operands, so decode stalls on RAW hazards and ALU writes never race a pending load (WAW).

Parameters:
- XLEN, 32, data width of a register write.
- NREGS, 32, architectural register count; 16 for RV32E builds. Writes to rd >= NREGS are dropped.
- TAG_DEPTH, 4, maximum outstanding loads (tag FIFO depth, power of two).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- load_issue_valid  in  1  load issued to memory
- load_issue_rd  in  5  load destination register
- load_issue_ready  out  1  tag slot available (combinational)
- load_done_valid  in  1  load data returned; cannot be back-pressured
- load_done_data  in  XLEN  returned load data
- rs1  in  5  decode source 1
- rs2  in  5  decode source 2
- busy1  out  1  rs1 has a write not yet visible in the register file
- busy2  out  1  rs2 has a write not yet visible in the register file
- regWrite  out  1  register file write enable (registered)
- writeRegister  out  5  write address (registered)
- writeData  out  XLEN  write data (registered)
- proto_err  out  1  sticky protocol error

Behaviour:
- Reset: regWrite=0, writeRegister=0, writeData=0, proto_err=0, tag FIFO empty, all busy outputs 0. Reset mid-operation discards all pending tags; load_done after reset with an empty FIFO counts as a protocol error.
- Tag FIFO:
  - Push on load_issue_valid && load_issue_ready.
  - Pop on load_done_valid && !empty.
  - load_issue_ready = !full || load_done_valid, so a simultaneous pop and push on a full FIFO is allowed.
  - Pointers wrap modulo TAG_DEPTH; count is held as TAG_DEPTH+1 states.
- Load completion:
  - Has absolute priority on the write port.
  - Popped tag with rd != 0 and rd < NREGS: next edge gives regWrite=1, writeRegister=tag, writeData=load_done_data.
  - Tag rd==0 or rd >= NREGS: popped, no write.
- ALU accept:
  - alu_ready = !load_done_valid && !tag_match(alu_rd).
  - tag_match(r) = any valid FIFO entry equals r, with r != 0.
  - On accept, if rd != 0 and rd < NREGS, next edge gives regWrite=1 with alu_rd/alu_data; otherwise no write.
- Write latency: exactly 1 cycle from accept/pop to regWrite high. regWrite is high for one cycle per write. writeRegister and writeData hold their last values when regWrite=0.
- busyN = (rsN != 0) && (tag_match(rsN) || (regWrite && writeRegister == rsN)). The second term covers the cycle where the registered write has not yet landed.
- proto_err is set when load_done_valid arrives with an empty FIFO; the data is dropped. It clears only on reset.
- Multiple pending loads to the same rd are legal. busy stays high until the last one is written.
- load_issue of rd in the same cycle as an ALU offer to the same rd: the push takes effect at the edge. tag_match uses pre-edge FIFO contents, so the ALU accept proceeds, which preserves program order.

Decomposition:
- Package regfile_pkg: XLEN, REG_ADDR_W=5, NREGS selected by RV32E define, TAG_DEPTH default.
- Sub-module wb_tag_fifo: tag storage, pointers, full/empty flags, and a parallel match output for three query addresses (alu_rd, rs1, rs2).

Test Plan:
- ALU write: alu_valid, rd=5, data=0xDEADBEEF, no loads -> alu_ready=1; next cycle regWrite=1, writeRegister=5, writeData=0xDEADBEEF; following cycle regWrite=0.
- RAW stall: issue load rd=7; rs1=7 -> busy1=1. load_done data=0x12345678 -> next cycle write x7=0x12345678 with busy1 still 1; the cycle after, busy1=0.
- Port conflict: load pending rd=3, then alu_valid rd=4 and load_done in the same cycle -> alu_ready=0, write x3 first; next cycle alu_ready=1, then write x4.
- WAW: load pending rd=9, alu_valid rd=9 -> alu_ready=0 until the load writes x9. The ALU write lands one cycle after the load write.
- Full FIFO: issue 4 loads (rd=1..4) -> load_issue_ready=0. 5th issue together with load_done -> accepted. Writes complete in order 1,2,3,4,5.
- x0 and error: load rd=0 completes -> no regWrite. load_done with an empty FIFO -> proto_err=1 and stays set until reset; reset clears proto_err, regWrite, and all busy outputs.
